// File: rtl/lfsr_param.sv
// -----------------------------------------------------------------------------
// lfsr_param
//   Parametrised LFSR pseudo-random generator.
//   - Fibonacci (shift left) or Galois (shift right) form, chosen by MODE.
//   - Step enable and parallel seed load.
//   - Recovery from the all-zero lock-up state.
//   - Period monitor: the number of steps between two visits of the start
//     value.
//   Typical use is as a stimulus or scrambler source. Downstream logic
//   consumes q in parallel or sout serially.
//
// Parameters
//   WIDTH  register width in bits (>= 2)
//   TAPS   feedback mask; TAPS[WIDTH-1] must be 1
//   MODE   0 = Fibonacci, 1 = Galois
//   SEED   reset / recovery value, must be non-zero
//
// Ports
//   clk       in   1      rising-edge clock
//   reset     in   1      synchronous, active-high reset
//   en        in   1      advance one step this cycle
//   load      in   1      load load_val this cycle (wins over en)
//   load_val  in   WIDTH  parallel seed value
//   q         out  WIDTH  current LFSR state
//   sout      out  1      serial output: q[WIDTH-1] (MODE 0) / q[0] (MODE 1)
//   wrap      out  1      1-cycle pulse: the step just taken returned to start
//   period    out  WIDTH  step count of the last completed cycle (0 = none yet)
//   lockup    out  1      1-cycle pulse: zero state or zero load replaced by SEED
//
// Control priority, evaluated at each rising clk edge:
//   reset > load > en > hold.
// All outputs come straight from registers. They reflect the operation that
// was sampled on the previous edge.
// -----------------------------------------------------------------------------
module lfsr_param #(
   parameter int               WIDTH = 3,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(3'b110),
   parameter int               MODE  = 0,
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(3'b001)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             wrap,
   output logic [WIDTH-1:0] period,
   output logic             lockup
);

   // State registers
   logic [WIDTH-1:0] q_r;       // current LFSR state
   logic [WIDTH-1:0] start_r;   // value the period monitor waits to see again
   logic [WIDTH-1:0] cnt_r;     // steps taken since start_r was last left
   logic [WIDTH-1:0] period_r;  // length of the last completed cycle
   logic             wrap_r;
   logic             lockup_r;

   // Combinational step and monitor values
   logic [WIDTH-1:0] q_step;    // state after one step from q_r
   logic [WIDTH-1:0] cnt_inc;   // cnt_r + 1, saturating at all-ones
   logic             q_zero;
   logic             load_zero;
   logic             hit_start;

   // ---------------------------------------------------------------------------
   // One LFSR step. The generate branch follows the MODE parameter, so only
   // one form of feedback is built.
   // ---------------------------------------------------------------------------
   generate
      if (MODE == 0) begin : g_fib
         logic fb;

         always_comb begin
            fb     = ^(q_r & TAPS);
            q_step = {q_r[WIDTH-2:0], fb};
         end

         assign sout = q_r[WIDTH-1];
      end else begin : g_gal
         // The bit shifted out of the LSB toggles every tapped position.
         always_comb begin
            q_step = (q_r >> 1) ^ (q_r[0] ? TAPS : '0);
         end

         assign sout = q_r[0];
      end
   endgenerate

   // Saturate the counter so a broken tap mask cannot make the period
   // report wrap around to a small, plausible-looking value.
   always_comb begin
      cnt_inc   = (cnt_r == '1) ? cnt_r : cnt_r + WIDTH'(1);
      q_zero    = (q_r == '0);
      load_zero = (load_val == '0);
      hit_start = (q_step == start_r);
   end

   // ---------------------------------------------------------------------------
   // Sequential update. The event pulses default low on every cycle, so each
   // one is high for exactly one clock after its cause.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         q_r      <= SEED;
         start_r  <= SEED;
         cnt_r    <= '0;
         period_r <= '0;
         wrap_r   <= 1'b0;
         lockup_r <= 1'b0;
      end else begin
         wrap_r   <= 1'b0;
         lockup_r <= 1'b0;

         if (load) begin
            // A zero seed would freeze the register, so SEED replaces it.
            // period is not touched: it still describes the last full cycle.
            if (load_zero) begin
               q_r      <= SEED;
               start_r  <= SEED;
               lockup_r <= 1'b1;
            end else begin
               q_r      <= load_val;
               start_r  <= load_val;
            end
            cnt_r <= '0;
         end else if (en) begin
            if (q_zero) begin
               // Zero is a fixed point of an XOR-only LFSR. It can only be
               // reached by something outside the design (a force or an upset).
               // Restart from SEED and do not report a wrap.
               q_r      <= SEED;
               start_r  <= SEED;
               cnt_r    <= '0;
               lockup_r <= 1'b1;
            end else begin
               q_r <= q_step;
               if (hit_start) begin
                  wrap_r   <= 1'b1;
                  period_r <= cnt_inc;
                  cnt_r    <= '0;
               end else begin
                  cnt_r    <= cnt_inc;
               end
            end
         end
      end
   end

   assign q      = q_r;
   assign wrap   = wrap_r;
   assign period = period_r;
   assign lockup = lockup_r;

endmodule

// File: tb/tb_lfsr_param.sv
// -----------------------------------------------------------------------------
// tb_lfsr_param
//   Directed bench for lfsr_param. It instantiates four copies:
//   - 3-bit, TAPS 110, in Fibonacci (_f) and Galois (_g) form. These share
//     reset, en, load and load_val.
//   - 8-bit, TAPS B8, in both forms, free-running from their own enable.
//   The expected 3-bit sequences are hand-computed cycle tables.
// -----------------------------------------------------------------------------
module tb_lfsr_param;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       en;
   logic       load;
   logic [2:0] load_val;
   logic       en8;
   logic       load8;
   logic [7:0] load_val8;

   // ---------------- DUT outputs ----------------
   logic [2:0] q_f, q_g, per_f, per_g;
   logic       sout_f, sout_g, wrap_f, wrap_g, lock_f, lock_g;
   logic [7:0] q8f, q8g, per8f, per8g;
   logic       sout8f, sout8g, wrap8f, wrap8g, lock8f, lock8g;

   lfsr_param #(.WIDTH(3), .TAPS(3'b110), .MODE(0), .SEED(3'b001)) dut_f (
      .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
      .q(q_f), .sout(sout_f), .wrap(wrap_f), .period(per_f), .lockup(lock_f));

   lfsr_param #(.WIDTH(3), .TAPS(3'b110), .MODE(1), .SEED(3'b001)) dut_g (
      .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
      .q(q_g), .sout(sout_g), .wrap(wrap_g), .period(per_g), .lockup(lock_g));

   lfsr_param #(.WIDTH(8), .TAPS(8'hB8), .MODE(0), .SEED(8'h01)) dut8_f (
      .clk(clk), .reset(reset), .en(en8), .load(load8), .load_val(load_val8),
      .q(q8f), .sout(sout8f), .wrap(wrap8f), .period(per8f), .lockup(lock8f));

   lfsr_param #(.WIDTH(8), .TAPS(8'hB8), .MODE(1), .SEED(8'h01)) dut8_g (
      .clk(clk), .reset(reset), .en(en8), .load(load8), .load_val(load_val8),
      .q(q8g), .sout(sout8g), .wrap(wrap8g), .period(per8g), .lockup(lock8g));

   // ---------------- expected cycles from 001 ----------------
   logic [2:0] cyc_f [0:6] = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100};
   logic [2:0] cyc_g [0:6] = '{3'b001, 3'b110, 3'b011, 3'b111, 3'b101, 3'b100, 3'b010};

   // ---------------- scoreboard ----------------
   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- driver helpers ----------------
   // Inputs change 1 time unit after a rising edge. Outputs are read at the
   // same point, well away from the next active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One step of both 3-bit copies, with the expected positions in the cycle
   // tables and the expected wrap pulse.
   task automatic chk3(input string tag, input int pf, input int pg, input bit exp_wrap);
      logic [2:0] ef;
      logic [2:0] eg;
      ef = cyc_f[pf % 7];
      eg = cyc_g[pg % 7];
      check($sformatf("%s q_f", tag), 32'(q_f), 32'(ef));
      check($sformatf("%s q_g", tag), 32'(q_g), 32'(eg));
      check($sformatf("%s sout_f", tag), 32'(sout_f), 32'(ef[2]));
      check($sformatf("%s sout_g", tag), 32'(sout_g), 32'(eg[0]));
      check($sformatf("%s wrap_f", tag), 32'(wrap_f), 32'(exp_wrap));
      check($sformatf("%s wrap_g", tag), 32'(wrap_g), 32'(exp_wrap));
      check($sformatf("%s lock_f", tag), 32'(lock_f), 32'(0));
   endtask

   // ---------------- stimulus ----------------
   initial begin : main
      int p;
      int first_f;
      int first_g;
      int nwrap_f;
      int nwrap_g;
      logic [7:0] q8f_at;
      logic [7:0] q8g_at;

      reset = 1'b1; en = 1'b0; load = 1'b0; load_val = 3'b000;
      en8 = 1'b0; load8 = 1'b0; load_val8 = 8'h00;
      tick();
      tick();

      // Reset state
      check("rst q_f", 32'(q_f), 32'(3'b001));
      check("rst q_g", 32'(q_g), 32'(3'b001));
      check("rst per_f", 32'(per_f), 32'(0));
      check("rst wrap_f", 32'(wrap_f), 32'(0));
      check("rst lock_g", 32'(lock_g), 32'(0));
      check("rst sout_f", 32'(sout_f), 32'(0));
      check("rst sout_g", 32'(sout_g), 32'(1));
      check("rst q8f", 32'(q8f), 32'(8'h01));

      // Free run of 7 steps in both forms; wrap on step 7
      reset = 1'b0;
      en    = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk3($sformatf("run%0d", k), k, k, k == 7);
      end
      check("run per_f", 32'(per_f), 32'(7));
      check("run per_g", 32'(per_g), 32'(7));

      // Load 111 with en=1: load wins, no step taken
      load = 1'b1; load_val = 3'b111;
      tick();
      load = 1'b0;
      chk3("ld111", 4, 3, 1'b0);
      check("ld111 per_f", 32'(per_f), 32'(7));
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk3($sformatf("ld111+%0d", k), 4 + k, 3 + k, k == 7);
      end

      // Load 000: SEED substituted, lockup pulses for one cycle
      load = 1'b1; load_val = 3'b000;
      tick();
      load = 1'b0; en = 1'b0;
      check("ld0 q_f", 32'(q_f), 32'(3'b001));
      check("ld0 q_g", 32'(q_g), 32'(3'b001));
      check("ld0 lock_f", 32'(lock_f), 32'(1));
      check("ld0 lock_g", 32'(lock_g), 32'(1));
      check("ld0 wrap_f", 32'(wrap_f), 32'(0));
      tick();
      check("ld0 hold lock_f", 32'(lock_f), 32'(0));
      check("ld0 hold q_f", 32'(q_f), 32'(3'b001));
      en = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk3($sformatf("ld0+%0d", k), k, k, k == 7);
      end

      // Alternating enable: advance only on en=1; never wrap on a hold cycle
      p = 0;
      for (int c = 0; c < 14; c++) begin
         en = (c % 2 == 0);
         tick();
         if (en) p++;
         chk3($sformatf("alt%0d", c), p, p, en && (p == 7));
         check($sformatf("alt%0d per_f", c), 32'(per_f), 32'(7));
      end

      // Reset pulsed on the 4th step
      en = 1'b1;
      for (int k = 1; k <= 3; k++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst q_f", 32'(q_f), 32'(3'b001));
      check("midrst q_g", 32'(q_g), 32'(3'b001));
      check("midrst per_f", 32'(per_f), 32'(0));
      check("midrst per_g", 32'(per_g), 32'(0));
      check("midrst wrap_f", 32'(wrap_f), 32'(0));
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk3($sformatf("postrst%0d", k), k, k, k == 7);
      end
      check("postrst per_f", 32'(per_f), 32'(7));

      // 8-bit, TAPS B8: period 255 in both forms
      en = 1'b0;
      en8 = 1'b1;
      first_f = -1; first_g = -1; nwrap_f = 0; nwrap_g = 0;
      q8f_at = 8'h00; q8g_at = 8'h00;
      for (int k = 1; k <= 300; k++) begin
         tick();
         if (k == 1) begin
            check("w8 per8f init", 32'(per8f), 32'(0));
            check("w8 per8g init", 32'(per8g), 32'(0));
         end
         if (k == 255) begin
            q8f_at = q8f;
            q8g_at = q8g;
         end
         if (wrap8f) begin
            nwrap_f++;
            if (first_f < 0) first_f = k;
         end
         if (wrap8g) begin
            nwrap_g++;
            if (first_g < 0) first_g = k;
         end
      end
      check("w8 first wrap f", 32'(first_f), 32'(255));
      check("w8 first wrap g", 32'(first_g), 32'(255));
      check("w8 wrap count f", 32'(nwrap_f), 32'(1));
      check("w8 wrap count g", 32'(nwrap_g), 32'(1));
      check("w8 q at 255 f", 32'(q8f_at), 32'(8'h01));
      check("w8 q at 255 g", 32'(q8g_at), 32'(8'h01));
      check("w8 per8f", 32'(per8f), 32'(255));
      check("w8 per8g", 32'(per8g), 32'(255));
      check("w8 lock8f", 32'(lock8f), 32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
